// File: rtl/test_pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : test_pe_ctrl_pkg
//  Description : Shared definitions for the PE operation scheduler.
//                PE opcode encodings (low 6 bits of op_code), the scheduler
//                FSM state type and the opcode legality check.
//  Revision    : 1.0  initial release
// ============================================================================
package test_pe_ctrl_pkg;

    // PE opcode encodings (op_code[5:0])
    localparam logic [5:0] PE_ADD_OP     = 6'h00;
    localparam logic [5:0] PE_SUB_OP     = 6'h01;
    localparam logic [5:0] PE_ABS_OP     = 6'h03;
    localparam logic [5:0] PE_GTE_MAX_OP = 6'h04;
    localparam logic [5:0] PE_LTE_MIN_OP = 6'h05;
    localparam logic [5:0] PE_EQ_OP      = 6'h06;
    localparam logic [5:0] PE_SEL_OP     = 6'h08;
    localparam logic [5:0] PE_MULT_0_OP  = 6'h0B;
    localparam logic [5:0] PE_MULT_1_OP  = 6'h0C;
    localparam logic [5:0] PE_MULT_2_OP  = 6'h0D;
    localparam logic [5:0] PE_ASHR_OP    = 6'h0E;
    localparam logic [5:0] PE_RSHFT_OP   = 6'h0F;
    localparam logic [5:0] PE_LSHFT_OP   = 6'h11;
    localparam logic [5:0] PE_OR_OP      = 6'h12;
    localparam logic [5:0] PE_AND_OP     = 6'h13;
    localparam logic [5:0] PE_XOR_OP     = 6'h14;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    // True when the low opcode bits name an operation the PE implements
    function automatic logic pe_op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            PE_ADD_OP, PE_SUB_OP, PE_ABS_OP, PE_GTE_MAX_OP, PE_LTE_MIN_OP,
            PE_EQ_OP, PE_SEL_OP, PE_MULT_0_OP, PE_MULT_1_OP, PE_MULT_2_OP,
            PE_ASHR_OP, PE_RSHFT_OP, PE_LSHFT_OP, PE_OR_OP, PE_AND_OP,
            PE_XOR_OP: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage : test_pe_ctrl_pkg
`default_nettype wire

// File: rtl/test_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : test_rr_arb
//  Description : Combinational round-robin arbiter. Searches req starting at
//                index ptr (wrapping) and returns the first set request.
//  Ports       : req      in  N     request vector
//                ptr      in  ID_W  highest-priority index (must be < N)
//                grant    out N     one-hot grant, zero if no request
//                grant_id out ID_W  encoded index of grant
//                any_req  out 1     at least one request set
//  Revision    : 1.0  initial release
// ============================================================================
module test_rr_arb #(
    parameter  int N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_req
);

    // One extra bit so ptr + offset can exceed N-1 before wrapping
    logic [ID_W:0] w_idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(N)) begin
                w_idx = w_idx - (ID_W+1)'(N);
            end
            if (!any_req && req[w_idx[ID_W-1:0]]) begin
                any_req                 = 1'b1;
                grant[w_idx[ID_W-1:0]]  = 1'b1;
                grant_id                = w_idx[ID_W-1:0];
            end
        end
    end

endmodule : test_rr_arb
`default_nettype wire

// File: rtl/test_pe_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : test_pe_op_sched
//  Description : Round-robin scheduler sharing one combinational PE datapath
//                between NUM_REQ requesters. One op is accepted per grant,
//                driven to the PE from registers, and the PE result is
//                returned with the requester id on a valid/ready channel.
//                Optional feature macro: TEST_PE_SCHED_STATS_EN adds
//                saturating per-requester grant counters and a stall counter.
//  Ports       : clk, rst_n (async active-low)
//                req_valid/req_ready/req_op/req_a/req_b/req_d_p  requesters
//                pe_op_code/pe_op_a/pe_op_b/pe_op_d_p            to PE
//                pe_res/pe_res_p                                 from PE
//                rsp_valid/rsp_ready/rsp_id/rsp_res/rsp_res_p/rsp_err
//                stat_grant_cnt/stat_stall_cnt (stats build only)
//  Revision    : 1.0  initial release
// ============================================================================
module test_pe_op_sched
    import test_pe_ctrl_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int DataWidth = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*9-1:0]           req_op,
    input  logic [NUM_REQ*DataWidth-1:0]   req_a,
    input  logic [NUM_REQ*DataWidth-1:0]   req_b,
    input  logic [NUM_REQ-1:0]             req_d_p,
    output logic [8:0]                     pe_op_code,
    output logic [DataWidth-1:0]           pe_op_a,
    output logic [DataWidth-1:0]           pe_op_b,
    output logic                           pe_op_d_p,
    input  logic [DataWidth-1:0]           pe_res,
    input  logic                           pe_res_p,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DataWidth-1:0]           rsp_res,
    output logic                           rsp_res_p,
`ifdef TEST_PE_SCHED_STATS_EN
    output logic                           rsp_err,
    output logic [NUM_REQ*16-1:0]          stat_grant_cnt,
    output logic [15:0]                    stat_stall_cnt
`else
    output logic                           rsp_err
`endif
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_id;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_any;
    logic                  w_can_grant;
    logic                  w_take;

    logic [8:0]            r_pe_op;
    logic [DataWidth-1:0]  r_pe_a;
    logic [DataWidth-1:0]  r_pe_b;
    logic                  r_pe_d_p;
    logic [ID_W-1:0]       r_rsp_id;
    logic [DataWidth-1:0]  r_rsp_res;
    logic                  r_rsp_res_p;
    logic                  r_rsp_err;

    test_rr_arb #(.N(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (r_rr_ptr),
        .grant    (w_grant),
        .grant_id (w_grant_id),
        .any_req  (w_any)
    );

    // Next state; a grant is possible in IDLE or on the response handshake
    always_comb begin
        w_state_nxt = r_state;
        w_can_grant = 1'b0;
        case (r_state)
            IDLE: begin
                w_can_grant = 1'b1;
                if (w_any) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_can_grant = 1'b1;
                    w_state_nxt = w_any ? EXEC : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // rst_n gates the comb accept so req_ready reads zero while in reset
    assign w_take    = w_can_grant & w_any & rst_n;
    assign req_ready = w_take ? w_grant : '0;
    assign rsp_valid = (r_state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_pe_op     <= 9'h0;
            r_pe_a      <= '0;
            r_pe_b      <= '0;
            r_pe_d_p    <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
            r_rsp_res_p <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_take) begin
                r_pe_op  <= req_op[w_grant_id*9 +: 9];
                r_pe_a   <= req_a[w_grant_id*DataWidth +: DataWidth];
                r_pe_b   <= req_b[w_grant_id*DataWidth +: DataWidth];
                r_pe_d_p <= req_d_p[w_grant_id];
                r_id     <= w_grant_id;
                r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ-1)) ? '0
                                                             : w_grant_id + ID_W'(1);
            end
            // The PE is combinational, so its result is valid throughout EXEC
            if (r_state == EXEC) begin
                r_rsp_id    <= r_id;
                r_rsp_res   <= pe_res;
                r_rsp_res_p <= pe_res_p;
                r_rsp_err   <= ~pe_op_legal(r_pe_op[5:0]);
            end
        end
    end

    assign pe_op_code = r_pe_op;
    assign pe_op_a    = r_pe_a;
    assign pe_op_b    = r_pe_b;
    assign pe_op_d_p  = r_pe_d_p;
    assign rsp_id     = r_rsp_id;
    assign rsp_res    = r_rsp_res;
    assign rsp_res_p  = r_rsp_res_p;
    assign rsp_err    = r_rsp_err;

`ifdef TEST_PE_SCHED_STATS_EN
    logic [15:0] r_stall_cnt;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (req_ready[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_grant_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
    assign stat_stall_cnt = r_stall_cnt;
`endif

endmodule : test_pe_op_sched
`default_nettype wire

// File: tb/tb_test_pe_op_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_pe_op_sched
//  Description : Self-checking bench for test_pe_op_sched. A small PE model
//                answers the registered pe_* outputs; expected responses are
//                queued at grant time and compared as responses handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_test_pe_op_sched;

    localparam int NR = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*9-1:0]   req_op = '0;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [NR-1:0]     req_d_p = '0;
    logic [8:0]        pe_op_code;
    logic [DW-1:0]     pe_op_a;
    logic [DW-1:0]     pe_op_b;
    logic              pe_op_d_p;
    logic [DW-1:0]     pe_res;
    logic              pe_res_p;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_res;
    logic              rsp_res_p;
    logic              rsp_err;
`ifdef TEST_PE_SCHED_STATS_EN
    logic [NR*16-1:0]  stat_grant_cnt;
    logic [15:0]       stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    test_pe_op_sched #(.NUM_REQ(NR), .DataWidth(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_d_p    (req_d_p),
        .pe_op_code (pe_op_code),
        .pe_op_a    (pe_op_a),
        .pe_op_b    (pe_op_b),
        .pe_op_d_p  (pe_op_d_p),
        .pe_res     (pe_res),
        .pe_res_p   (pe_res_p),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_res    (rsp_res),
        .rsp_res_p  (rsp_res_p),
`ifdef TEST_PE_SCHED_STATS_EN
        .rsp_err        (rsp_err),
        .stat_grant_cnt (stat_grant_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`else
        .rsp_err    (rsp_err)
`endif
    );

    // Stand-in PE: a few real ops, everything else passes op_a / op_d_p
    function automatic logic [DW-1:0] pe_fn(logic [8:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op[5:0])
            6'h00:   return a + b;
            6'h01:   return a - b;
            6'h12:   return a | b;
            6'h13:   return a & b;
            6'h14:   return a ^ b;
            default: return a;
        endcase
    endfunction

    always_comb begin
        pe_res   = pe_fn(pe_op_code, pe_op_a, pe_op_b);
        pe_res_p = pe_op_d_p;
    end

    function automatic logic legal(logic [5:0] o);
        case (o)
            6'h00, 6'h01, 6'h03, 6'h04, 6'h05, 6'h06, 6'h08, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h11, 6'h12, 6'h13, 6'h14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] res;
        logic          res_p;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t m_exp;
    rsp_t m_got;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic rsp_t model(int r, logic [8:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic dp);
        rsp_t e;
        e.id    = 2'(r);
        e.res   = pe_fn(op, a, b);
        e.res_p = dp;
        e.err   = ~legal(op[5:0]);
        return e;
    endfunction

    // Response monitor / scoreboard checker
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            n_vec++;
            m_got = {rsp_id, rsp_res, rsp_res_p, rsp_err};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rsp_unexpected got id=%0d res=%h p=%b err=%b", rsp_id, rsp_res, rsp_res_p, rsp_err);
            end else begin
                m_exp = sb.pop_front();
                if (m_got !== m_exp) begin
                    n_err++;
                    $display("FAIL rsp got id=%0d res=%h p=%b err=%b exp id=%0d res=%h p=%b err=%b",
                             m_got.id, m_got.res, m_got.res_p, m_got.err,
                             m_exp.id, m_exp.res, m_exp.res_p, m_exp.err);
                end
            end
        end
    end

    task automatic drive_req(int r, logic [8:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic dp);
        req_op[r*9 +: 9]   = op;
        req_a[r*DW +: DW]  = a;
        req_b[r*DW +: DW]  = b;
        req_d_p[r]         = dp;
    endtask

    task automatic wait_empty(string name);
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s pending responses got %0d exp 0", name, sb.size());
        end
    endtask

    task automatic issue_one(int r, logic [8:0] op, logic [DW-1:0] a, logic [DW-1:0] b, logic dp);
        bit granted = 0;
        @(posedge clk); #1;
        drive_req(r, op, a, b, dp);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 10 && !granted; i++) begin
            @(negedge clk);
            if (req_ready[r] === 1'b1) granted = 1;
        end
        n_vec++;
        if (!granted) begin
            n_err++;
            $display("FAIL grant_req%0d got no grant exp grant", r);
        end else begin
            sb.push_back(model(r, op, a, b, dp));
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        wait_empty("issue");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, rsp_valid, pe_op_code, pe_op_a, pe_op_b, pe_op_d_p,
             rsp_id, rsp_res, rsp_res_p, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL reset_state got rdy=%b v=%b op=%h a=%h b=%h res=%h exp all zero",
                     req_ready, rsp_valid, pe_op_code, pe_op_a, pe_op_b, rsp_res);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rr();
        logic [NR-1:0] exp_g;
        for (int r = 0; r < NR; r++) drive_req(r, 9'h000, 16'(100*r + 1), 16'(r + 3), r[0]);
        for (int k = 0; k < 5; k++) sb.push_back(model(k % NR, 9'h000, 16'(100*(k%NR) + 1), 16'((k%NR) + 3), k[0]));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            exp_g = NR'(1) << (k % NR);
            @(negedge clk);
            n_vec++;
            if (req_ready !== exp_g) begin
                n_err++;
                $display("FAIL rr_grant%0d got %b exp %b", k, req_ready, exp_g);
            end
            @(negedge clk);
            n_vec++;
            if (req_ready !== '0) begin
                n_err++;
                $display("FAIL rr_exec_ready%0d got %b exp 0000", k, req_ready);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_empty("rr");
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        drive_req(1, 9'h000, 16'd5, 16'd7, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL single_ready got %b exp 0010", req_ready);
        end
        sb.push_back('{id: 2'd1, res: 16'd12, res_p: 1'b0, err: 1'b0});
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_exec_valid got %b exp 0", rsp_valid);
        end
        @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_latency got %b exp 1", rsp_valid);
        end
        wait_empty("single");
    endtask

    task automatic test_illegal();
        issue_one(2, 9'h007, 16'h1234, 16'h5555, 1'b1);
        issue_one(3, 9'h1C0, 16'h0102, 16'h0304, 1'b0);
        issue_one(0, 9'h002, 16'hBEEF, 16'h0001, 1'b1);
        issue_one(1, 9'h014, 16'hF0F0, 16'h0FF0, 1'b0);
        issue_one(2, 9'h010, 16'h7777, 16'h1111, 1'b0);
        issue_one(3, 9'h015, 16'h4242, 16'h1111, 1'b1);
        issue_one(0, 9'h001, 16'h0010, 16'h0011, 1'b1);
    endtask

    task automatic test_backpressure();
        rsp_t e0;
        e0 = model(0, 9'h014, 16'hA5A5, 16'h0F0F, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(0, 9'h014, 16'hA5A5, 16'h0F0F, 1'b1);
        req_valid = 4'b0001;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_grant0 got %b exp 0001", req_ready);
        end
        sb.push_back(e0);
        @(posedge clk); #1;
        drive_req(1, 9'h013, 16'h3C3C, 16'hFF00, 1'b0);
        req_valid = 4'b0010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== '0) begin
            n_err++;
            $display("FAIL bp_exec_ready got %b exp 0000", req_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || req_ready !== '0 ||
                {rsp_id, rsp_res, rsp_res_p, rsp_err} !== e0) begin
                n_err++;
                $display("FAIL bp_hold%0d got v=%b rdy=%b res=%h exp v=1 rdy=0000 res=%h",
                         k, rsp_valid, req_ready, rsp_res, e0.res);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_handshake_grant got %b exp 0010", req_ready);
        end
        sb.push_back(model(1, 9'h013, 16'h3C3C, 16'hFF00, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        wait_empty("bp");
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        @(posedge clk); #1;
        drive_req(1, 9'h000, 16'h00AA, 16'h0001, 1'b1);
        req_valid = 4'b0010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL rstmid_grant got %b exp 0010", req_ready);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, rsp_valid, pe_op_code, pe_op_a, pe_op_b, pe_op_d_p,
             rsp_id, rsp_res, rsp_res_p, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async got rdy=%b v=%b op=%h a=%h exp all zero",
                     req_ready, rsp_valid, pe_op_code, pe_op_a);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL rstmid_no_rsp got rsp_valid=1 exp 0");
        end
        @(posedge clk); #1;
        drive_req(0, 9'h012, 16'h1200, 16'h0034, 1'b0);
        drive_req(3, 9'h000, 16'h0001, 16'h0001, 1'b1);
        req_valid = 4'b1001;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rstmid_first_grant got %b exp 0001", req_ready);
        end
        sb.push_back(model(0, 9'h012, 16'h1200, 16'h0034, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        wait_empty("rstmid");
    endtask

`ifdef TEST_PE_SCHED_STATS_EN
    task automatic test_stats();
        bit got_v = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        issue_one(3, 9'h000, 16'd1, 16'd2, 1'b0);
        issue_one(3, 9'h001, 16'd9, 16'd2, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_req(3, 9'h014, 16'h00FF, 16'h0F0F, 1'b0);
        req_valid = 4'b1000;
        @(negedge clk);
        sb.push_back(model(3, 9'h014, 16'h00FF, 16'h0F0F, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 6 && !got_v; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got_v = 1;
        end
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_empty("stats");
        n_vec++;
        if (stat_grant_cnt[48 +: 16] !== 16'd3 || stat_stall_cnt !== 16'd4) begin
            n_err++;
            $display("FAIL stats got grant3=%0d stall=%0d exp grant3=3 stall=4",
                     stat_grant_cnt[48 +: 16], stat_stall_cnt);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_illegal();
        test_backpressure();
        test_reset_mid();
`ifdef TEST_PE_SCHED_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_test_pe_op_sched
`default_nettype wire
